tbird_signal_ctrl: RTL and testbench

//   Request arbiter and sequencer in front of the Thunderbird tail-lamp FSM.

---
 rtl/tbird_pkg.sv | 24 ++
 rtl/tbird_signal_ctrl_if.sv | 28 ++
 rtl/tbird_prescaler.sv | 27 ++
 rtl/tbird_signal_ctrl.sv | 76 +++++++
 tb/tb_tbird_signal_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/tbird_pkg.sv
// Shared types for the Thunderbird tail-lamp blocks: the granted mode encoding
// and the request arbitration rule used at every decision point.
package tbird_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } mode_t;

    // Both turn requests together are treated as a hazard request.
    function automatic mode_t arbitrate(input logic left, input logic right, input logic hazard);
        if (hazard || (left && right))
            return HAZARD;
        else if (left)
            return LEFT;
        else if (right)
            return RIGHT;
        else
            return IDLE;
    endfunction

endpackage

// File: rtl/tbird_signal_ctrl_if.sv
// Request and command bundle between the driver-side requests, the signal
// controller and the lamp FSM.
interface tbird_signal_ctrl_if #(
    parameter int STEP_W = 2
);
    import tbird_pkg::*;

    logic              req_left;
    logic              req_right;
    logic              req_hazard;
    logic              tick;
    logic              cmd_left;
    logic              cmd_right;
    mode_t             mode;
    logic [STEP_W-1:0] seq_step;
    logic              busy;

    modport master (
        output req_left, req_right, req_hazard,
        input  tick, cmd_left, cmd_right, mode, seq_step, busy
    );

    modport slave (
        input  req_left, req_right, req_hazard,
        output tick, cmd_left, cmd_right, mode, seq_step, busy
    );

endinterface

// File: rtl/tbird_prescaler.sv
// Lamp tick generator: a free-running 0..TICK_DIV-1 counter whose last count
// is decoded into a one-cycle clock-enable pulse.
module tbird_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (div_cnt == CNT_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + CNT_W'(1);
    end

    // Decoded from the register so the first tick lands TICK_DIV-1 cycles after reset.
    assign tick = (div_cnt == CNT_LAST);

endmodule

// File: rtl/tbird_signal_ctrl.sv
// Request arbiter and sequencer in front of the tail-lamp FSM; direction changes
// are only granted at blink-sequence boundaries so a sweep is never cut short.
//
//   state  | meaning
//   IDLE   | no lamp activity; every tick is a decision point
//   LEFT   | left sweep in progress, seq_step advances per tick
//   RIGHT  | right sweep in progress, seq_step advances per tick
//   HAZARD | both sides sweep together
module tbird_signal_ctrl
    import tbird_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int SEQ_LEN  = 4
) (
    input  logic                clk,
    input  logic                reset,
    tbird_signal_ctrl_if.slave  bus
);
    localparam int STEP_W = $clog2(SEQ_LEN);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SEQ_LEN - 1);

    logic              tick;
    mode_t             mode_q;
    mode_t             mode_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic              cmd_left_q;
    logic              cmd_right_q;
    logic              busy_q;

    tbird_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= IDLE;
            step_q      <= '0;
            cmd_left_q  <= 1'b0;
            cmd_right_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            step_q      <= step_d;
            cmd_left_q  <= (mode_d == LEFT)  || (mode_d == HAZARD);
            cmd_right_q <= (mode_d == RIGHT) || (mode_d == HAZARD);
            busy_q      <= (mode_d != IDLE);
        end
    end

    // Requests only matter in tick cycles; a dropped request still finishes its sweep.
    always_comb begin
        mode_d = mode_q;
        step_d = step_q;
        if (tick) begin
            if ((mode_q == IDLE) || (step_q == STEP_LAST)) begin
                step_d = '0;
                mode_d = arbitrate(bus.req_left, bus.req_right, bus.req_hazard);
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
    end

    assign bus.tick      = tick;
    assign bus.mode      = mode_q;
    assign bus.seq_step  = step_q;
    assign bus.cmd_left  = cmd_left_q;
    assign bus.cmd_right = cmd_right_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_tbird_signal_ctrl.sv
// Bench for tbird_signal_ctrl: directed scenarios plus random requests, all
// outputs compared every cycle against an integer reference model of the rules.
module tb_tbird_signal_ctrl;
    import tbird_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int SEQ_LEN  = 4;
    localparam int STEP_W   = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // reference model: cycle count since reset (mod TICK_DIV), granted mode, step
    int m_cnt;
    int m_mode;
    int m_step;

    tbird_signal_ctrl_if #(.STEP_W(STEP_W)) bus ();

    tbird_signal_ctrl #(
        .TICK_DIV (TICK_DIV),
        .SEQ_LEN  (SEQ_LEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("tick",      8'(bus.tick),      8'(m_cnt == TICK_DIV - 1));
        chk("mode",      8'(bus.mode),      8'(m_mode));
        chk("seq_step",  8'(bus.seq_step),  8'(m_step));
        chk("cmd_left",  8'(bus.cmd_left),  8'(m_mode == 1 || m_mode == 3));
        chk("cmd_right", 8'(bus.cmd_right), 8'(m_mode == 2 || m_mode == 3));
        chk("busy",      8'(bus.busy),      8'(m_mode != 0));
    endtask

    task automatic set_req(input logic l, input logic r, input logic h);
        bus.req_left   = l;
        bus.req_right  = r;
        bus.req_hazard = h;
    endtask

    // One clock: check at the falling edge, then advance the model on the rising edge.
    task automatic cyc();
        logic l, r, h, t;
        @(negedge clk);
        check_outputs();
        l = bus.req_left;
        r = bus.req_right;
        h = bus.req_hazard;
        t = (m_cnt == TICK_DIV - 1);
        @(posedge clk);
        if (t) begin
            if (m_mode == 0 || m_step == SEQ_LEN - 1) begin
                m_step = 0;
                if (h || (l && r))
                    m_mode = 3;
                else if (l)
                    m_mode = 1;
                else if (r)
                    m_mode = 2;
                else
                    m_mode = 0;
            end else begin
                m_step = m_step + 1;
            end
        end
        m_cnt = (m_cnt + 1) % TICK_DIV;
        #1;
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_mode = 0;
        m_step = 0;
    endtask

    // Called just after a rising edge; holds reset across one edge.
    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit found;

        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0);
        model_clear();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        // idle prescaler: ticks at 3, 7, 11 cycles after release, mode stays IDLE
        repeat (12) cyc();
        chk("t1_idle_mode", 8'(bus.mode), 8'd0);

        // left held from release: LEFT granted and sweeps repeat
        do_reset();
        set_req(1'b1, 1'b0, 1'b0);
        repeat (20) cyc();
        chk("t2_left_mode", 8'(bus.mode), 8'd1);

        // switch to right mid-sweep: change only at sequence end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_mode == 1 && m_step == 1) found = 1'b1;
            else cyc();
        end
        chk("t3_reach_step1", 8'(found), 8'd1);
        set_req(1'b0, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (m_mode == 2) found = 1'b1;
        end
        chk("t3_switched", 8'(found), 8'd1);
        chk("t3_cmd_left_off", 8'(bus.cmd_left), 8'd0);
        chk("t3_cmd_right_on", 8'(bus.cmd_right), 8'd1);

        // both turns -> hazard; hazard with left -> hazard
        do_reset();
        set_req(1'b1, 1'b1, 1'b0);
        repeat (6) cyc();
        chk("t4_lr_hazard", 8'(bus.mode), 8'd3);
        do_reset();
        set_req(1'b1, 1'b0, 1'b1);
        repeat (6) cyc();
        chk("t4_hl_hazard", 8'(bus.mode), 8'd3);

        // one-cycle right pulse off-tick is ignored; on-tick gives one full sweep
        do_reset();
        set_req(1'b0, 1'b0, 1'b0);
        cyc();
        set_req(1'b0, 1'b1, 1'b0);
        cyc();
        set_req(1'b0, 1'b0, 1'b0);
        repeat (6) cyc();
        chk("t5_offtick_ignored", 8'(bus.mode), 8'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_cnt == TICK_DIV - 1) found = 1'b1;
            else cyc();
        end
        chk("t5_tick_align", 8'(found), 8'd1);
        set_req(1'b0, 1'b1, 1'b0);
        cyc();
        set_req(1'b0, 1'b0, 1'b0);
        chk("t5_right_granted", 8'(bus.mode), 8'd2);
        repeat (SEQ_LEN * TICK_DIV) cyc();
        chk("t5_back_idle", 8'(bus.mode), 8'd0);

        // async reset mid-sweep in HAZARD at seq_step 2
        do_reset();
        set_req(1'b0, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_mode == 3 && m_step == 2) found = 1'b1;
            else cyc();
        end
        chk("t6_reach_step2", 8'(found), 8'd1);
        set_req(1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) cyc();

        // random requests, changed at random cycles
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0)
                set_req(1'($urandom_range(1)), 1'($urandom_range(1)),
                        1'($urandom_range(7) == 0));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
